// File: rtl/mrdust_edge_tx_if.sv
// mrdust_edge_tx_if: request/status bundle between a frame requester and the edge transmitter
interface mrdust_edge_tx_if;
   logic        start;
   logic [3:0]  meta;
   logic [15:0] scan_len;
   logic        abort;
   logic        DATA_OUT;
   logic        busy;
   logic        done;
   modport master (output start, meta, scan_len, abort, input DATA_OUT, busy, done);
   modport slave (input start, meta, scan_len, abort, output DATA_OUT, busy, done);
endinterface

// File: rtl/mrdust_edge_tx.sv
// mrdust_edge_tx: single-wire edge transmitter (3 sync, meta-start, 4 pulse-width bits, scan-start, scan edges)
module mrdust_edge_tx #(
   parameter int SYNC_GAP  = 1000,
   parameter int BIT_LONG  = 12,
   parameter int BIT_SHORT = 4,
   parameter int SCAN_GAP  = 100,
   parameter int SCAN_HALF = 50
) (
   input logic             CLK_IN,
   input logic             rst_n,
   mrdust_edge_tx_if.slave bus
);
   typedef enum logic [2:0] {IDLE, SYNC, BIT_A, BIT_B, SCAN_WAIT, SCAN, FINISH} state_t;
   localparam logic [15:0] SYNC_RL  = 16'(SYNC_GAP - 1);
   localparam logic [15:0] LONG_RL  = 16'(BIT_LONG - 1);
   localparam logic [15:0] SHORT_RL = 16'(BIT_SHORT - 1);
   localparam logic [15:0] GAP_RL   = 16'(SCAN_GAP - 1);
   localparam logic [15:0] HALF_RL  = 16'(SCAN_HALF - 1);
   state_t      r_state;
   logic [15:0] r_timer;
   logic [15:0] r_cnt;
   logic [15:0] r_scan_len;
   logic [3:0]  r_meta;
   logic [1:0]  r_bit;
   logic        r_data;
   logic        r_busy;
   logic        r_done;
   logic        w_fire;
   logic [1:0]  w_nbit;
   logic [15:0] w_a0_rl;
   logic [15:0] w_an_rl;
   logic [15:0] w_b_rl;
   assign w_fire  = r_timer == 16'd0;
   assign w_nbit  = r_bit + 2'd1;
   // a 1 bit is long-then-short, a 0 bit short-then-long
   assign w_a0_rl = r_meta[0] ? LONG_RL : SHORT_RL;
   assign w_an_rl = r_meta[w_nbit] ? LONG_RL : SHORT_RL;
   assign w_b_rl  = r_meta[r_bit] ? SHORT_RL : LONG_RL;
   assign bus.DATA_OUT = r_data;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   always_ff @(posedge CLK_IN) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_timer    <= '0;
         r_cnt      <= '0;
         r_scan_len <= '0;
         r_meta     <= '0;
         r_bit      <= '0;
         r_data     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_busy && bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
         end else begin
            r_timer <= w_fire ? r_timer : r_timer - 16'd1;
            case (r_state)
               IDLE: if (bus.start) begin
                  r_state    <= SYNC;
                  r_busy     <= 1'b1;
                  r_meta     <= bus.meta;
                  r_scan_len <= bus.scan_len;
                  r_timer    <= '0;
                  r_cnt      <= '0;
                  r_bit      <= '0;
               end
               // edges 0..2 are sync, edge 3 is the metadata start
               SYNC: if (w_fire) begin
                  r_data  <= ~r_data;
                  r_cnt   <= r_cnt + 16'd1;
                  r_state <= r_cnt == 16'd3 ? BIT_A : SYNC;
                  r_timer <= r_cnt == 16'd3 ? w_a0_rl : SYNC_RL;
               end
               BIT_A: if (w_fire) begin
                  r_data  <= ~r_data;
                  r_state <= BIT_B;
                  r_timer <= w_b_rl;
               end
               BIT_B: if (w_fire) begin
                  r_data  <= ~r_data;
                  r_bit   <= w_nbit;
                  r_state <= r_bit == 2'd3 ? SCAN_WAIT : BIT_A;
                  r_timer <= r_bit == 2'd3 ? GAP_RL : w_an_rl;
               end
               SCAN_WAIT: if (w_fire) begin
                  r_data  <= ~r_data;
                  r_cnt   <= '0;
                  r_timer <= HALF_RL;
                  r_state <= r_scan_len == 16'd0 ? FINISH : SCAN;
               end
               SCAN: if (w_fire) begin
                  r_data  <= ~r_data;
                  r_cnt   <= r_cnt + 16'd1;
                  r_timer <= HALF_RL;
                  r_state <= r_cnt + 16'd1 == r_scan_len ? FINISH : SCAN;
               end
               FINISH: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mrdust_edge_tx.sv
// tb_mrdust_edge_tx: scoreboard bench for edge timing, done pulses, abort, reset and back-to-back frames
module tb_mrdust_edge_tx;
   localparam int G = 20, BL = 12, BS = 4, SG = 100, SH = 50;
   logic CLK_IN = 1'b0;
   logic rst_n = 1'b0;
   logic prev = 1'b0;
   int cyc = 0, checks = 0, errors = 0, n_edges = 0, m_e = 0;
   int exp_q[$], done_q[$], act_q[$];
   mrdust_edge_tx_if bus ();
   mrdust_edge_tx #(.SYNC_GAP(G)) dut (.CLK_IN(CLK_IN), .rst_n(rst_n), .bus(bus.slave));
   always #5 CLK_IN = ~CLK_IN;
   always @(posedge CLK_IN) cyc <= cyc + 1;
   always @(negedge CLK_IN) begin
      if (rst_n && bus.DATA_OUT !== prev) begin
         n_edges++;
         act_q.push_back(cyc);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL edge: unexpected toggle at cycle %0d", cyc);
         end else begin
            m_e = exp_q.pop_front();
            if (m_e != cyc) begin
               errors++;
               $display("FAIL edge: toggle at cycle %0d, expected cycle %0d", cyc, m_e);
            end
         end
      end
      if (rst_n && bus.done === 1'b1) begin
         checks++;
         if (done_q.size() == 0) begin
            errors++;
            $display("FAIL done: unexpected done at cycle %0d", cyc);
         end else begin
            m_e = done_q.pop_front();
            if (m_e != cyc) begin
               errors++;
               $display("FAIL done: pulse at cycle %0d, expected cycle %0d", cyc, m_e);
            end
         end
      end
      prev = bus.DATA_OUT;
   end
   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   task automatic push_frame(input int p, input logic [3:0] m, input int sl, output int d);
      int t = p + 1;
      exp_q.push_back(t);
      for (int k = 0; k < 3; k++) begin
         t += G;
         exp_q.push_back(t);
      end
      for (int i = 0; i < 4; i++) begin
         t += m[i] ? BL : BS;
         exp_q.push_back(t);
         t += m[i] ? BS : BL;
         exp_q.push_back(t);
      end
      t += SG;
      exp_q.push_back(t);
      for (int k = 0; k < sl; k++) begin
         t += SH;
         exp_q.push_back(t);
      end
      d = t + 1;
      done_q.push_back(d);
   endtask
   task automatic start_frame(input logic [3:0] m, input int sl, output int p);
      int d;
      @(negedge CLK_IN);
      bus.start = 1'b1;
      bus.meta = m;
      bus.scan_len = 16'(sl);
      p = cyc + 1;
      push_frame(p, m, sl, d);
      @(negedge CLK_IN);
      bus.start = 1'b0;
   endtask
   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int k = 0; k < 2000 && !ok; k++) begin
         @(negedge CLK_IN);
         ok = exp_q.size() == 0 && done_q.size() == 0 && bus.busy === 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: frame incomplete, %0d edges and %0d done pulses outstanding", name, exp_q.size(), done_q.size());
         exp_q.delete();
         done_q.delete();
      end
   endtask
   task automatic test_reset();
      bus.start = 1'b1;
      bus.meta = 4'hF;
      bus.scan_len = 16'd2;
      bus.abort = 1'b0;
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge CLK_IN);
         checks += 3;
         if (bus.DATA_OUT !== 1'b0) begin errors++; $display("FAIL reset_data: got %b want 0", bus.DATA_OUT); end
         if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
         if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      end
      bus.start = 1'b0;
      rst_n = 1'b1;
      repeat (10) @(negedge CLK_IN);
      checks++;
      if (bus.DATA_OUT !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: data %b busy %b want 0 0", bus.DATA_OUT, bus.busy);
      end
   endtask
   task automatic test_scan_zero();
      int p, n0;
      logic l0 = bus.DATA_OUT;
      start_frame(4'b0101, 0, p);
      n0 = n_edges;
      wait_idle("scan_zero");
      checks += 2;
      if (n_edges - n0 != 13) begin errors++; $display("FAIL scan_zero_count: got %0d edges want 13", n_edges - n0); end
      if (bus.DATA_OUT !== ~l0) begin errors++; $display("FAIL scan_zero_level: got %b want %b", bus.DATA_OUT, ~l0); end
   endtask
   task automatic test_frame();
      int p, n0;
      logic l0 = bus.DATA_OUT;
      start_frame(4'b1010, 4, p);
      n0 = n_edges;
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL frame_busy: got %b want 1", bus.busy); end
      wait_idle("frame");
      checks += 2;
      if (n_edges - n0 != 17) begin errors++; $display("FAIL frame_count: got %0d edges want 17", n_edges - n0); end
      if (bus.DATA_OUT !== ~l0) begin errors++; $display("FAIL frame_level: got %b want %b", bus.DATA_OUT, ~l0); end
   endtask
   task automatic test_meta_decode();
      int p;
      logic [3:0] dec = '0;
      start_frame(4'b0110, 3, p);
      act_q.delete();
      wait_idle("meta_decode");
      checks++;
      if (act_q.size() != 16) begin
         errors++;
         $display("FAIL decode_count: got %0d edges want 16", act_q.size());
      end else begin
         for (int i = 0; i < 4; i++)
            dec[i] = (act_q[4 + 2 * i] - act_q[3 + 2 * i]) > (act_q[5 + 2 * i] - act_q[4 + 2 * i]);
         checks++;
         if (dec !== 4'b0110) begin errors++; $display("FAIL decode_meta: got %b want 0110", dec); end
      end
   endtask
   task automatic test_abort();
      int p, e8, d;
      logic l0 = bus.DATA_OUT;
      start_frame(4'b0011, 5, p);
      e8 = exp_q[8];
      while (exp_q.size() > 9) void'(exp_q.pop_back());
      done_q.delete();
      while (cyc < e8 + 1) @(negedge CLK_IN);
      bus.abort = 1'b1;
      @(negedge CLK_IN);
      bus.abort = 1'b0;
      checks += 3;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", bus.done); end
      if (bus.DATA_OUT !== ~l0) begin errors++; $display("FAIL abort_level: got %b want %b", bus.DATA_OUT, ~l0); end
      repeat (40) @(negedge CLK_IN);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL abort_edges: %0d edges missing before abort", exp_q.size()); end
      exp_q.delete();
      bus.abort = 1'b1;
      @(negedge CLK_IN);
      bus.start = 1'b1;
      bus.meta = 4'b1111;
      bus.scan_len = 16'd1;
      p = cyc + 1;
      push_frame(p, 4'b1111, 1, d);
      @(negedge CLK_IN);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      wait_idle("abort_restart");
      checks++;
      if (bus.DATA_OUT !== ~l0) begin errors++; $display("FAIL restart_level: got %b want %b", bus.DATA_OUT, ~l0); end
   endtask
   task automatic test_back_to_back();
      int p1, d1, d2;
      @(negedge CLK_IN);
      bus.start = 1'b1;
      bus.meta = 4'b1001;
      bus.scan_len = 16'd2;
      p1 = cyc + 1;
      push_frame(p1, 4'b1001, 2, d1);
      push_frame(d1 + 1, 4'b0101, 3, d2);
      @(negedge CLK_IN);
      bus.meta = 4'b0101;
      bus.scan_len = 16'd3;
      while (cyc < d1) @(negedge CLK_IN);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy: got %b want 0", bus.busy); end
      @(negedge CLK_IN);
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy: got %b want 1", bus.busy); end
      wait_idle("back_to_back");
   endtask
   task automatic test_reset_mid();
      int p, tgt;
      logic l0 = bus.DATA_OUT;
      start_frame(4'b0000, 2, p);
      tgt = l0 ? exp_q[1] : exp_q[0];
      while (cyc < tgt) @(negedge CLK_IN);
      checks++;
      if (bus.DATA_OUT !== 1'b1) begin errors++; $display("FAIL mid_pre_level: got %b want 1", bus.DATA_OUT); end
      rst_n = 1'b0;
      @(negedge CLK_IN);
      exp_q.delete();
      done_q.delete();
      checks += 2;
      if (bus.DATA_OUT !== 1'b0) begin errors++; $display("FAIL mid_reset_data: got %b want 0", bus.DATA_OUT); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", bus.busy); end
      @(negedge CLK_IN);
      rst_n = 1'b1;
      repeat (60) @(negedge CLK_IN);
      checks++;
      if (bus.DATA_OUT !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_after: data %b busy %b want 0 0", bus.DATA_OUT, bus.busy);
      end
   endtask
   initial begin
      test_reset();
      test_scan_zero();
      test_frame();
      test_meta_decode();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0 || done_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_end: %0d edges %0d done outstanding, want 0 0", exp_q.size(), done_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mrdust_edge_tx.md
Name: mrdust_edge_tx

Overview:
- Transmitter end of the mrdust single-wire edge protocol. Drives the level line that the mote FSM's edge detector samples.
- Every protocol event is one toggle of DATA_OUT. A frame is three sync edges, one metadata-start edge, four pulse-width-encoded metadata bits, one scan-start edge, then a programmable number of alternating-current scan edges.
- Sits in the base-station/test-harness FPGA, clocked from the same CLK_IN domain as the receiver under test.

Parameters:
- SYNC_GAP, 1000: cycles between consecutive sync edges, and from the third sync edge to the metadata-start edge (1..65535).
- BIT_LONG, 12: cycles of the long interval of a metadata bit.
- BIT_SHORT, 4: cycles of the short interval of a metadata bit. Legal range: 1 <= BIT_SHORT < BIT_LONG <= BIT_SHORT+15.
- SCAN_GAP, 100: cycles from the last metadata edge to the scan-start edge.
- SCAN_HALF, 50: cycles between scan edges, i.e. half-period of the SendPos/SendNeg alternation.

Ports:
- CLK_IN  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  frame request; sampled only in IDLE.
- meta  input  4  metadata nibble; latched on start accept; meta[0] is sent first.
- scan_len  input  16  number of scan edges after the scan-start edge; latched on start accept.
- abort  input  1  terminates the frame at the next clock.
- DATA_OUT  output  1  protocol line; each toggle is one edge.
- busy  output  1  high from the cycle after start accept until return to IDLE.
- done  output  1  one-cycle pulse on normal frame completion.

Behaviour:
- Reset (rst_n=0 at posedge): DATA_OUT=0, busy=0, done=0, state=IDLE, counters cleared. Reset overrides abort and start. Reset mid-frame stops all toggling immediately; DATA_OUT is forced to 0 even if it is 1.
- Registered outputs only. A toggle is scheduled by a 16-bit down-counter `timer` plus a state register.
- IDLE: DATA_OUT holds its level. On start=1, latch meta and scan_len, then go to SYNC. The first sync toggle occurs at the posedge after the accept cycle, so latency start→first edge is 1 cycle. busy rises in the same cycle.
- SYNC: emits 3 toggles spaced SYNC_GAP cycles apart. The metadata-start toggle follows the third sync toggle by SYNC_GAP cycles. Then go to BIT_A with bit index i=0.
- Metadata bit i:
  - BIT_A lasts A cycles, then toggles and goes to BIT_B.
  - BIT_B lasts B cycles, then toggles.
  - meta[i]=1: A=BIT_LONG, B=BIT_SHORT. meta[i]=0: A=BIT_SHORT, B=BIT_LONG.
  - The BIT_B closing toggle of bit i is also the opening reference of bit i+1. There is no separate start edge per bit.
  - After i=3, go to SCAN_WAIT.
- SCAN_WAIT: toggle after SCAN_GAP cycles (scan-start, receiver enters SendPos).
  - scan_len=0: go to FINISH.
  - Otherwise go to SCAN.
- SCAN: toggle every SCAN_HALF cycles. A 16-bit edge counter counts up to scan_len, then goes to FINISH.
- FINISH: done=1 for one cycle, busy=0, state returns to IDLE. A start asserted in the FINISH cycle is ignored; it is accepted from IDLE on the following cycle.
- Edge count per frame = 3 + 1 + 8 + 1 + scan_len. DATA_OUT is not returned to 0 between frames. The next frame toggles from the current level.
- abort=1 while busy: next posedge returns to IDLE with no toggle in that cycle, done stays 0, busy drops, DATA_OUT holds. abort in IDLE has no effect.
- start while busy is ignored. meta and scan_len changes after accept have no effect.
- Timer reload: timer loads (interval−1) on each toggle, and a toggle fires when timer==0. Intervals are therefore exact cycle counts between toggles.

Test Plan:
- Reset: rst_n=0 for 3 cycles with start=1 → DATA_OUT=0, busy=0, done=0; no toggle until start is re-asserted with rst_n=1.
- Frame with meta=4'b1010, scan_len=4, SYNC_GAP=20 (override), defaults otherwise:
  - Toggle at cycle 1, then at +20, +20, +20 (metadata start).
  - Bit gaps: 4,12 | 12,4 | 4,12 | 12,4.
  - Then +100 (scan start), then 4 toggles every 50 cycles.
  - done pulses 1 cycle after the last toggle; 17 toggles total.
- Loopback into the mote receiver with meta=4'b0110 → receiver dataStorage=0110; receiver state walks SendPos/SendNeg alternately on each scan edge.
- scan_len=0 → 13 toggles, done on the cycle after the scan-start toggle; DATA_OUT ends at 1.
- abort asserted during BIT_B of bit 2 → no further toggles, done=0, busy=0 next cycle; a new start then begins a fresh 3-edge sync from the held level.
- start held high continuously → back-to-back frames separated by exactly one IDLE cycle after done; start pulses during busy produce no extra edges.
